// File: rtl/z80_rot_dec_sequencer.sv
// z80_rot_dec_sequencer
//
// Multi-cycle sequencer for the Z80 RRD / RLD rotate-decimal instructions.
// It owns the memory port for the whole instruction. The sequence is:
//   1. read (HL);
//   2. wait COMPUTE_CYCLES internal cycles;
//   3. write the rotated byte back to (HL);
//   4. present the new A and F with a one-cycle done pulse.
//
// Parameters
//   COMPUTE_CYCLES  Cycles spent in COMPUTE between read ack and write issue (>= 1).
//
// Ports
//   clk, reset_n         Core clock (posedge); asynchronous active-low reset.
//   start                Launch pulse from the decoder. It is only honoured in IDLE.
//   left                 1 = RLD, 0 = RRD. Captured when start is accepted.
//   hl, a_in, f_in       Operand address, accumulator and flags. Captured when start is accepted.
//   busy                 High from the cycle after an accepted start through DONE.
//   done                 One-cycle completion pulse.
//   a_out, f_out         New A / F. These update only on write ack and hold until the next done.
//   mem_addr             Captured hl during READ/WRITE, otherwise 0.
//   mem_rd, mem_wr       Read / write requests. They are mutually exclusive.
//   mem_wdata            Rotated byte during WRITE, otherwise 0.
//   mem_rdata, mem_ack   Read data and request completion. The ack may come in the same
//                        cycle as the request.
module z80_rot_dec_sequencer #(
    parameter int COMPUTE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        left,
    input  logic [15:0] hl,
    input  logic [7:0]  a_in,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  a_out,
    output logic [7:0]  f_out,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam int CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMPUTE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Operands latched on an accepted start.
    logic        left_q;
    logic [15:0] hl_q;
    logic [7:0]  a_q;
    logic [7:0]  f_q;

    // The result is captured on read ack, so the write data and the new A/F
    // are stable through COMPUTE and WRITE however long the write waits.
    logic [7:0]  a_res;
    logic [7:0]  f_res;
    logic [7:0]  m_res;

    logic [CNT_W-1:0] cnt;

    // Strobes decoded from the next-state logic.
    logic accept;
    logic rd_done;
    logic wr_done;
    logic cnt_dec;

    // Combinational result from the latched operands and the incoming read data.
    logic [7:0] a_new;
    logic [7:0] m_new;
    logic [7:0] f_new;

    always_comb begin
        if (left_q) begin
            a_new = {a_q[7:4], mem_rdata[7:4]};
            m_new = {mem_rdata[3:0], a_q[3:0]};
        end else begin
            a_new = {a_q[7:4], mem_rdata[3:0]};
            m_new = {a_q[3:0], mem_rdata[7:4]};
        end
        // Flag layout is {S, Z, 5, H, 3, PV, N, C}.
        // Undocumented bits 5 and 3, and the carry, pass through from F.
        // XNOR-reduce gives 1 for an even number of ones (parity even).
        f_new = {a_new[7], (a_new == 8'h00), f_q[5], 1'b0,
                 f_q[3], ~^a_new, 1'b0, f_q[0]};
    end

    // Next-state and Moore outputs. Every bus output decodes from the state
    // register, so an asynchronous reset drops requests immediately.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        cnt_dec   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                mem_rd   = 1'b1;
                mem_addr = hl_q;
                if (mem_ack) begin
                    rd_done   = 1'b1;
                    state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (cnt == '0) state_nxt = S_WRITE;
                else           cnt_dec   = 1'b1;
            end
            S_WRITE: begin
                mem_wr    = 1'b1;
                mem_addr  = hl_q;
                mem_wdata = m_res;
                if (mem_ack) begin
                    wr_done   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A start that arrives here is dropped; the decoder must re-issue it.
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_q <= 1'b0;
            hl_q   <= 16'h0000;
            a_q    <= 8'h00;
            f_q    <= 8'h00;
        end else if (accept) begin
            left_q <= left;
            hl_q   <= hl;
            a_q    <= a_in;
            f_q    <= f_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_res <= 8'h00;
            f_res <= 8'h00;
            m_res <= 8'h00;
            cnt   <= '0;
        end else if (rd_done) begin
            a_res <= a_new;
            f_res <= f_new;
            m_res <= m_new;
            cnt   <= CNT_LOAD;
        end else if (cnt_dec) begin
            cnt   <= cnt - 1'b1;
        end
    end

    // Architectural outputs move only on write ack. An aborted instruction
    // therefore never exposes a partial result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_out <= 8'h00;
            f_out <= 8'h00;
        end else if (wr_done) begin
            a_out <= a_res;
            f_out <= f_res;
        end
    end

endmodule

// File: tb/tb_z80_rot_dec_sequencer.sv
module tb_z80_rot_dec_sequencer;

    localparam int CC = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        left;
    logic [15:0] hl;
    logic [7:0]  a_in;
    logic [7:0]  f_in;
    logic        busy;
    logic        done;
    logic [7:0]  a_out;
    logic [7:0]  f_out;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int n_tests = 0;
    int n_fail  = 0;

    // Last completed architectural result; reset clears it.
    logic [7:0] exp_a = 8'h00;
    logic [7:0] exp_f = 8'h00;

    z80_rot_dec_sequencer #(.COMPUTE_CYCLES(CC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .left(left), .hl(hl),
        .a_in(a_in), .f_in(f_in), .busy(busy), .done(done), .a_out(a_out),
        .f_out(f_out), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {A', F', M'} straight from the RLD/RRD definitions.
    function automatic logic [23:0] ref_op(input bit lft, input logic [7:0] a,
                                           input logic [7:0] f, input logic [7:0] m);
        logic [7:0] an, mn, fn;
        int ones;
        if (lft) begin
            an = a & 8'hF0 | (m >> 4);
            mn = (m << 4) | (a & 8'h0F);
        end else begin
            an = a & 8'hF0 | (m & 8'h0F);
            mn = ((a & 8'h0F) << 4) | (m >> 4);
        end
        ones = $countones(an);
        fn = 8'h00;
        if (an >= 8'h80)    fn = fn | 8'h80;
        if (an == 8'h00)    fn = fn | 8'h40;
        fn = fn | (f & 8'h29);              // bits 5, 3, C pass through
        if (ones % 2 == 0)  fn = fn | 8'h04;
        return {an, fn, mn};
    endfunction

    // Launch one instruction and act as the memory.
    //   rd_wait / wr_wait : ack latency in cycles.
    //   noise             : toggle start randomly while busy.
    //   abort             : pull reset on the first WRITE cycle.
    task automatic run_op(input bit lft, input logic [15:0] addr, input logic [7:0] a,
                          input logic [7:0] f, input logic [7:0] m,
                          input int rd_wait, input int wr_wait, input bit noise, input bit abort);
        logic [23:0] r;
        int cyc, rd_seen, wr_seen, bus_bad, done_cyc;
        bit fin;
        r = ref_op(lft, a, f, m);
        cyc = 0; rd_seen = 0; wr_seen = 0; bus_bad = 0; done_cyc = 0; fin = 0;

        @(negedge clk);
        start = 1'b1; left = lft; hl = addr; a_in = a; f_in = f; mem_ack = 1'b0;
        @(posedge clk);                      // cycle 0: start accepted

        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = noise ? 1'($urandom) : 1'b0;
            // Scramble the operand inputs to prove that they were latched.
            left = 1'($urandom); hl = 16'($urandom); a_in = 8'($urandom); f_in = 8'($urandom);
            mem_ack = 1'b0; mem_rdata = 8'($urandom);
            if (cyc == 1) begin
                chk("a_out_held", 32'(a_out), 32'(exp_a));
                chk("f_out_held", 32'(f_out), 32'(exp_f));
            end
            if (!busy) bus_bad++;
            if (mem_rd && mem_wr) bus_bad++;
            if (mem_rd) begin
                if (mem_addr !== addr || mem_wdata !== 8'h00) bus_bad++;
                if (rd_seen >= rd_wait) begin mem_ack = 1'b1; mem_rdata = m; end
                rd_seen++;
            end else if (mem_wr) begin
                if (abort) begin
                    reset_n = 1'b0;
                    #1;
                    chk("rst_mem_wr", 32'(mem_wr), 0);
                    chk("rst_busy",   32'(busy), 0);
                    chk("rst_a_out",  32'(a_out), 0);
                    chk("rst_f_out",  32'(f_out), 0);
                    exp_a = 8'h00; exp_f = 8'h00;
                    start = 1'b0; mem_ack = 1'b0;
                    @(negedge clk);
                    reset_n = 1'b1;
                    return;
                end
                if (mem_addr !== addr || mem_wdata !== r[7:0]) bus_bad++;
                if (wr_seen == 0) chk("wdata", 32'(mem_wdata), 32'(r[7:0]));
                if (wr_seen >= wr_wait) mem_ack = 1'b1;
                wr_seen++;
            end else if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin
                bus_bad++;
            end
            if (done) begin
                fin = 1; done_cyc = cyc;
                if (noise) start = 1'b1;     // a start in DONE must be dropped
                chk("a_out", 32'(a_out), 32'(r[23:16]));
                chk("f_out", 32'(f_out), 32'(r[15:8]));
            end
        end

        if (!fin) begin
            chk("timeout", 0, 1);
        end else begin
            chk("done_cycle", 32'(done_cyc), 32'(CC + 3 + rd_wait + wr_wait));
            chk("rd_cycles", 32'(rd_seen), 32'(rd_wait + 1));
            chk("wr_cycles", 32'(wr_seen), 32'(wr_wait + 1));
        end
        chk("bus_rules", 32'(bus_bad), 0);
        exp_a = r[23:16]; exp_f = r[15:8];

        @(negedge clk);
        start = 1'b0;
        chk("done_single", 32'(done), 0);
        chk("idle_after",  32'(busy), 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; left = 1'b0; hl = 16'h0; a_in = 8'h0; f_in = 8'h0;
        mem_rdata = 8'h0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy0",  32'(busy), 0);
        chk("rst_done0",  32'(done), 0);
        chk("rst_rd0",    32'(mem_rd), 0);
        chk("rst_wr0",    32'(mem_wr), 0);
        chk("rst_addr0",  32'(mem_addr), 0);
        chk("rst_wdata0", 32'(mem_wdata), 0);
        chk("rst_a0",     32'(a_out), 0);
        chk("rst_f0",     32'(f_out), 0);
        reset_n = 1'b1;

        // RLD, A=0x12, M=0x34: writes 0x42 and gives A=0x13.
        run_op(1'b1, 16'h8000, 8'h12, 8'h00, 8'h34, 0, 0, 1'b0, 1'b0);
        chk("t1_a", 32'(a_out), 32'h13);
        // RRD, A=0x12, M=0x34: gives A=0x14 and F=0x04 (two ones, so PV=1).
        run_op(1'b0, 16'h1234, 8'h12, 8'h00, 8'h34, 0, 0, 1'b0, 1'b0);
        chk("t2_a", 32'(a_out), 32'h14);
        chk("t2_f", 32'(f_out), 32'h04);
        // RLD, A=0x00, M=0x0F, F=0x29: gives A=0x00 and F=0x6D.
        run_op(1'b1, 16'h4000, 8'h00, 8'h29, 8'h0F, 0, 0, 1'b0, 1'b0);
        chk("t3_a", 32'(a_out), 32'h00);
        chk("t3_f", 32'(f_out), 32'h6D);
        // Delayed acks.
        run_op(1'b0, 16'hBEEF, 8'hA5, 8'hFF, 8'h5A, 3, 0, 1'b0, 1'b0);
        run_op(1'b1, 16'hCAFE, 8'h3C, 8'h00, 8'hC3, 0, 3, 1'b0, 1'b0);
        // Stray starts while busy and in DONE.
        run_op(1'b1, 16'h0101, 8'h77, 8'h01, 8'h88, 1, 1, 1'b1, 1'b0);
        // Reset during WRITE, then a clean run.
        run_op(1'b1, 16'h2222, 8'h9F, 8'h29, 8'h61, 0, 2, 1'b0, 1'b1);
        run_op(1'b0, 16'h3333, 8'h5E, 8'h08, 8'hE7, 0, 0, 1'b0, 1'b0);
        // Randomized instructions.
        for (int i = 0; i < 25; i++)
            run_op(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
